// File: rtl/nand_target_pkg.sv
// rtl/nand_target_pkg.sv - opcodes, state encoding and status layout for the NAND target responder
package nand_target_pkg;

  localparam logic [7:0] CMD_READ       = 8'h00;
  localparam logic [7:0] CMD_READ_CONF  = 8'h30;
  localparam logic [7:0] CMD_PROG       = 8'h80;
  localparam logic [7:0] CMD_PROG_CONF  = 8'h10;
  localparam logic [7:0] CMD_ERASE      = 8'h60;
  localparam logic [7:0] CMD_ERASE_CONF = 8'hD0;
  localparam logic [7:0] CMD_STATUS     = 8'h70;
  localparam logic [7:0] CMD_RESET      = 8'hFF;

  localparam int STAT_WP_BIT   = 7;
  localparam int STAT_RDY_BIT  = 6;
  localparam int STAT_FAIL_BIT = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_CONF,
    ST_PG_ADDR,
    ST_PG_DATA,
    ST_ER_ADDR,
    ST_ER_CONF,
    ST_BUSY,
    ST_DOUT_ARR,
    ST_DOUT_STAT
  } state_e;

  // What the busy period does and where it lands: read -> data out, everything else -> idle.
  typedef enum logic [1:0] {
    BK_READ,
    BK_ERASE,
    BK_HOLD
  } busy_kind_e;

  function automatic logic [7:0] status_byte(input logic wp, input logic rdy, input logic fail);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_WP_BIT]   = wp;
    s[STAT_RDY_BIT]  = rdy;
    s[STAT_FAIL_BIT] = fail;
    return s;
  endfunction

endpackage

// File: rtl/nand_page_array.sv
// rtl/nand_page_array.sv - single-port page RAM, registered read, read-first on write
module nand_page_array #(
  parameter int AW = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/nand_target_responder.sv
// rtl/nand_target_responder.sv - NAND die model: bus-cycle decode, command FSM, busy timing, DQ drive
module nand_target_responder
  import nand_target_pkg::*;
#(
  parameter int PAGE_BYTES = 16,
  parameter int NUM_PAGES  = 4,
  parameter int T_R        = 8,
  parameter int T_PROG     = 32,
  parameter int T_RST      = 4
) (
  input  logic       clock_100,
  input  logic       rst,
  input  logic       ce_n,
  input  logic       cle,
  input  logic       ale,
  input  logic       wr_n,
  input  logic       strobe,
  input  logic       wp_n,
  input  logic [7:0] dq_in,
  output logic [7:0] dq_out,
  output logic       dq_oe,
  output logic       rb_n,
  output logic       proto_err
);

  localparam int CW = $clog2(PAGE_BYTES);
  localparam int RW = $clog2(NUM_PAGES);
  localparam int BW = 16;

  state_e        state_q, ret_q, base_state, done_state;
  busy_kind_e    kind_q;
  logic [BW-1:0] busy_cnt_q;
  logic [1:0]    addr_cnt_q;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          fail_q, proto_err_q, dq_oe_q, rb_n_q;
  logic [7:0]    dq_out_q;

  logic bus_cyc, is_cmd, is_addr, is_din, is_dout;
  logic busy_expire, erase_wr, pg_din, din_wr, mem_we;
  logic [RW+CW-1:0] mem_addr;
  logic [7:0]       mem_wdata, mem_rdata;

  assign bus_cyc = strobe & ~ce_n;
  assign is_cmd  = bus_cyc &  cle & ~ale &  wr_n;
  assign is_addr = bus_cyc &  ale & ~cle &  wr_n;
  assign is_din  = bus_cyc & ~cle & ~ale &  wr_n;
  assign is_dout = bus_cyc & ~cle & ~ale & ~wr_n;

  assign busy_expire = ~rb_n_q & (busy_cnt_q == BW'(1));
  assign done_state  = (kind_q == BK_READ) ? ST_DOUT_ARR : ST_IDLE;

  // Commands are judged against the interrupted state when status is being read,
  // and against the post-busy state when the busy period ends on this very edge.
  always_comb begin
    base_state = (state_q == ST_DOUT_STAT) ? ret_q : state_q;
    if (busy_expire && base_state == ST_BUSY) base_state = done_state;
  end

  assign erase_wr = ~rb_n_q & (kind_q == BK_ERASE);
  assign pg_din   = is_din & (state_q == ST_PG_DATA);
  assign din_wr   = pg_din & wp_n;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (erase_wr || pg_din || (is_dout && state_q == ST_DOUT_ARR)) col_d = col_q + 1'b1;
    if (is_addr) begin
      if (state_q == ST_RD_ADDR || state_q == ST_PG_ADDR) begin
        if (addr_cnt_q == 2'd0) col_d = dq_in[CW-1:0];
        if (addr_cnt_q == 2'd2) row_d = dq_in[RW-1:0];
      end
      if (state_q == ST_ER_ADDR) row_d = dq_in[RW-1:0];
    end
    if (is_cmd && dq_in == CMD_ERASE_CONF && base_state == ST_ER_CONF) col_d = '0;
  end

  // Reads track the next column so data for the following DOUT is always prefetched.
  assign mem_we    = erase_wr | din_wr;
  assign mem_addr  = mem_we ? {row_q, col_q} : {row_d, col_d};
  assign mem_wdata = erase_wr ? 8'hFF : dq_in;

  nand_page_array #(
    .AW(RW + CW)
  ) u_array (
    .clk_i  (clock_100),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clock_100 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_IDLE;
      kind_q      <= BK_HOLD;
      busy_cnt_q  <= '0;
      addr_cnt_q  <= '0;
      col_q       <= '0;
      row_q       <= '0;
      fail_q      <= 1'b0;
      proto_err_q <= 1'b0;
      dq_out_q    <= 8'h00;
      dq_oe_q     <= 1'b0;
      rb_n_q      <= 1'b1;
    end else begin
      col_q <= col_d;
      row_q <= row_d;

      if (ce_n || (strobe && wr_n)) dq_oe_q <= 1'b0;
      if (bus_cyc && cle && ale) proto_err_q <= 1'b1;

      if (!rb_n_q) begin
        busy_cnt_q <= busy_cnt_q - 1'b1;
        if (busy_expire) begin
          rb_n_q <= 1'b1;
          if (state_q == ST_BUSY) state_q <= done_state;
          else if (ret_q == ST_BUSY) ret_q <= done_state;
        end
      end

      if (ce_n && (state_q inside {ST_RD_ADDR, ST_RD_CONF, ST_PG_ADDR, ST_PG_DATA,
                                   ST_ER_ADDR, ST_ER_CONF})) begin
        state_q <= ST_IDLE;
      end

      if (is_cmd) begin
        if (dq_in == CMD_RESET) begin
          state_q     <= ST_BUSY;
          kind_q      <= BK_HOLD;
          busy_cnt_q  <= BW'(T_RST);
          rb_n_q      <= 1'b0;
          fail_q      <= 1'b0;
          proto_err_q <= 1'b0;
        end else if (dq_in == CMD_STATUS) begin
          state_q <= ST_DOUT_STAT;
          ret_q   <= base_state;
        end else if (base_state == ST_BUSY) begin
          state_q <= ST_BUSY;
        end else begin
          case (dq_in)
            CMD_READ: begin
              state_q    <= ST_RD_ADDR;
              addr_cnt_q <= 2'd0;
            end
            CMD_PROG: begin
              state_q    <= ST_PG_ADDR;
              addr_cnt_q <= 2'd0;
            end
            CMD_ERASE: state_q <= ST_ER_ADDR;
            CMD_READ_CONF: begin
              if (base_state == ST_RD_CONF) begin
                state_q    <= ST_BUSY;
                kind_q     <= BK_READ;
                busy_cnt_q <= BW'(T_R);
                rb_n_q     <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
              end
            end
            CMD_PROG_CONF: begin
              if (base_state == ST_PG_DATA) begin
                state_q    <= ST_BUSY;
                kind_q     <= BK_HOLD;
                busy_cnt_q <= BW'(T_PROG);
                rb_n_q     <= 1'b0;
                fail_q     <= ~wp_n;
              end else begin
                state_q <= ST_IDLE;
              end
            end
            CMD_ERASE_CONF: begin
              if (base_state == ST_ER_CONF) begin
                state_q    <= ST_BUSY;
                kind_q     <= wp_n ? BK_ERASE : BK_HOLD;
                busy_cnt_q <= BW'(PAGE_BYTES);
                rb_n_q     <= 1'b0;
                fail_q     <= ~wp_n;
              end else begin
                state_q <= ST_IDLE;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end

      if (is_addr) begin
        case (state_q)
          ST_RD_ADDR, ST_PG_ADDR: begin
            addr_cnt_q <= addr_cnt_q + 2'd1;
            if (addr_cnt_q == 2'd2)
              state_q <= (state_q == ST_RD_ADDR) ? ST_RD_CONF : ST_PG_DATA;
          end
          ST_ER_ADDR: state_q <= ST_ER_CONF;
          default: ;
        endcase
      end

      // A status read on the expiry edge already reports ready.
      if (is_dout) begin
        if (state_q == ST_DOUT_ARR) begin
          dq_out_q <= mem_rdata;
          dq_oe_q  <= 1'b1;
        end else if (state_q == ST_DOUT_STAT) begin
          dq_out_q <= status_byte(wp_n, rb_n_q | busy_expire, fail_q);
          dq_oe_q  <= 1'b1;
        end
      end
    end
  end

  assign dq_out    = dq_out_q;
  assign dq_oe     = dq_oe_q;
  assign rb_n      = rb_n_q;
  assign proto_err = proto_err_q;

endmodule
